// File: rtl/ndf_page_reader.sv
// ndf_page_reader: one NAND page read (00h, address cycles, 30h, R/B wait, byte stream out)
// Ports: clk_ndf/rst_n clock and async active-low reset; start/ce_sel/col_addr/row_addr/byte_count
// request; busy/done/timeout_err status; out_data/out_valid/out_ready byte stream;
// ndf_* flash pins (r_b_n and io_in in, io_out/io_oe/ce_n/cle/ale/we_n/re_n/wp_n out).
module ndf_page_reader #(
    parameter int ADDR_CYCLES = 5,
    parameter int TWB_CYC     = 4,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int CNT_W       = 14
) (
    input  logic             clk_ndf,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ce_sel,
    input  logic [15:0]      col_addr,
    input  logic [23:0]      row_addr,
    input  logic [CNT_W-1:0] byte_count,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             ndf_r_b_n,
    input  logic [7:0]       ndf_io_in,
    output logic [7:0]       ndf_io_out,
    output logic             ndf_io_oe,
    output logic [1:0]       ndf_ce_n,
    output logic             ndf_cle,
    output logic             ndf_ale,
    output logic             ndf_we_n,
    output logic             ndf_re_n,
    output logic             ndf_wp_n
);
    localparam int TW = $clog2((TIMEOUT_CYC > TWB_CYC ? TIMEOUT_CYC : TWB_CYC) + 1);
    localparam logic [2:0] LAST = 3'(ADDR_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_W1, S_W2, S_TWB, S_WAIT, S_R1, S_R2, S_R3, S_RWAIT, S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rem_q;
    logic [39:0] addr_q;
    logic sel_q, sel_d;
    logic [1:0] rb_q;
    logic go, accept, tmo_fire, wr_d, busy_d;
    logic [7:0] wr_byte;
    logic busy_q, done_q, tmo_q, valid_q, oe_q, cle_q, ale_q, we_n_q, re_n_q;
    logic [7:0] data_q, io_q;
    logic [1:0] ce_n_q;

    assign go     = state_q == S_IDLE && start;
    assign accept = valid_q && out_ready;
    assign sel_d  = go ? ce_sel : sel_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tmo_fire = 1'b0;
        case (state_q)
            S_IDLE:  state_d = start ? S_SETUP : S_IDLE;
            S_SETUP: begin
                state_d = S_W1;
                idx_d   = '0;
            end
            S_W1:    state_d = S_W2;
            S_W2:    begin
                state_d = idx_q == LAST ? S_TWB : S_W1;
                idx_d   = idx_q == LAST ? idx_q : idx_q + 3'd1;
            end
            S_TWB:   state_d = cnt_q == TW'(TWB_CYC - 1) ? S_WAIT : S_TWB;
            S_WAIT:  begin
                if (rb_q[1])
                    state_d = rem_q == '0 ? S_DONE : S_R1;
                else if (cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d  = S_DONE;
                    tmo_fire = 1'b1;
                end
            end
            S_R1:    state_d = S_R2;
            S_R2:    state_d = S_R3;
            // a new R1 only starts once the held byte is being taken
            S_R3, S_RWAIT: state_d = accept ? (rem_q == '0 ? S_DONE : S_R1) : S_RWAIT;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        cnt_d   = (state_d == state_q && (state_q == S_TWB || state_q == S_WAIT)) ? cnt_q + 1'b1 : '0;
        wr_d    = state_d == S_W1 || state_d == S_W2;
        wr_byte = idx_d == '0 ? 8'h00 : idx_d == LAST ? 8'h30 : 8'(addr_q >> {idx_d - 3'd1, 3'b000});
        busy_d  = state_d != S_IDLE && state_d != S_DONE;
    end

    // outputs are registered from the next state so they line up with the state they belong to
    always_ff @(posedge clk_ndf or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            addr_q  <= '0;
            sel_q   <= 1'b0;
            rb_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ce_n_q  <= 2'b11;
            cle_q   <= 1'b0;
            ale_q   <= 1'b0;
            we_n_q  <= 1'b1;
            re_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            io_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rb_q    <= {rb_q[0], ndf_r_b_n};
            sel_q   <= sel_d;
            if (go) begin
                addr_q <= {row_addr, col_addr};
                rem_q  <= byte_count;
            end else if (state_q == S_R2) begin
                rem_q  <= rem_q - 1'b1;
            end
            if (state_q == S_R2)
                data_q <= ndf_io_in;
            valid_q <= state_q == S_R2 || (valid_q && !out_ready);
            busy_q  <= busy_d;
            done_q  <= state_d == S_DONE;
            tmo_q   <= tmo_fire;
            ce_n_q  <= busy_d ? (sel_d ? 2'b01 : 2'b10) : 2'b11;
            cle_q   <= wr_d && (idx_d == '0 || idx_d == LAST);
            ale_q   <= wr_d && !(idx_d == '0 || idx_d == LAST);
            we_n_q  <= state_d != S_W1;
            re_n_q  <= !(state_d == S_R1 || state_d == S_R2);
            oe_q    <= wr_d;
            io_q    <= wr_d ? wr_byte : 8'h00;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = tmo_q;
    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign ndf_ce_n    = ce_n_q;
    assign ndf_cle     = cle_q;
    assign ndf_ale     = ale_q;
    assign ndf_we_n    = we_n_q;
    assign ndf_re_n    = re_n_q;
    assign ndf_io_oe   = oe_q;
    assign ndf_io_out  = io_q;
    assign ndf_wp_n    = 1'b0;
endmodule

// File: tb/tb_ndf_page_reader.sv
// tb_ndf_page_reader: table-driven bench with flash model and byte scoreboard
module tb_ndf_page_reader;
    localparam int TWB = 4;
    localparam logic [28:0] RST_PK = {2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00,
                                      1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

    logic clk_ndf = 1'b0;
    always #25 clk_ndf = ~clk_ndf;

    logic rst_n, start, ce_sel, out_ready, rb, use_b;
    logic [15:0] col_addr;
    logic [23:0] row_addr;
    logic [13:0] byte_count;
    logic [7:0] io_in;
    logic start_a, start_b;
    assign start_a = start && !use_b;
    assign start_b = start && use_b;

    logic a_busy, a_done, a_to, a_ov, a_oe, a_cle, a_ale, a_we_n, a_re_n, a_wp_n;
    logic b_busy, b_done, b_to, b_ov, b_oe, b_cle, b_ale, b_we_n, b_re_n, b_wp_n;
    logic [7:0] a_od, a_io, b_od, b_io;
    logic [1:0] a_ce_n, b_ce_n;
    logic [28:0] a_pk, b_pk, m_pk;
    logic m_busy, m_done, m_to, m_ov, m_oe, m_cle, m_ale, m_we_n, m_re_n, m_wp_n;
    logic [7:0] m_od, m_io;
    logic [1:0] m_ce_n;

    assign a_pk = {a_ce_n, a_cle, a_ale, a_we_n, a_re_n, a_wp_n, a_oe, a_io, a_busy, a_done, a_to, a_ov, a_od};
    assign b_pk = {b_ce_n, b_cle, b_ale, b_we_n, b_re_n, b_wp_n, b_oe, b_io, b_busy, b_done, b_to, b_ov, b_od};
    assign m_pk = use_b ? b_pk : a_pk;
    assign {m_ce_n, m_cle, m_ale, m_we_n, m_re_n, m_wp_n, m_oe, m_io, m_busy, m_done, m_to, m_ov, m_od} = m_pk;

    ndf_page_reader #(.TIMEOUT_CYC(200)) u_a (
        .clk_ndf(clk_ndf), .rst_n(rst_n), .start(start_a), .ce_sel(ce_sel),
        .col_addr(col_addr), .row_addr(row_addr), .byte_count(byte_count),
        .busy(a_busy), .done(a_done), .timeout_err(a_to), .out_data(a_od),
        .out_valid(a_ov), .out_ready(out_ready), .ndf_r_b_n(rb), .ndf_io_in(io_in),
        .ndf_io_out(a_io), .ndf_io_oe(a_oe), .ndf_ce_n(a_ce_n), .ndf_cle(a_cle),
        .ndf_ale(a_ale), .ndf_we_n(a_we_n), .ndf_re_n(a_re_n), .ndf_wp_n(a_wp_n)
    );

    ndf_page_reader #(.ADDR_CYCLES(4)) u_b (
        .clk_ndf(clk_ndf), .rst_n(rst_n), .start(start_b), .ce_sel(ce_sel),
        .col_addr(col_addr), .row_addr(row_addr), .byte_count(byte_count),
        .busy(b_busy), .done(b_done), .timeout_err(b_to), .out_data(b_od),
        .out_valid(b_ov), .out_ready(out_ready), .ndf_r_b_n(rb), .ndf_io_in(io_in),
        .ndf_io_out(b_io), .ndf_io_oe(b_oe), .ndf_ce_n(b_ce_n), .ndf_cle(b_cle),
        .ndf_ale(b_ale), .ndf_we_n(b_we_n), .ndf_re_n(b_re_n), .ndf_wp_n(b_wp_n)
    );

    typedef struct {
        logic        use_b;
        logic        sel;
        logic [15:0] col;
        logic [23:0] row;
        logic [13:0] cnt;
        int          rb_busy;
        int          stall_after;
        logic        again;
        logic        start_done;
        logic [1:0]  exp_ce;
        int          exp_nwr;
        int          exp_re;
        logic        exp_to;
    } vec_t;

    vec_t tv[5];
    int checks = 0, errors = 0;
    int t, t30, first_we, done_cnt, done_t, re_pulses, re_low, rd_idx, proto_err;
    int stall_re_err, stall_cnt, stall_after, acc, rb_cnt, rb_rise, rb_busy;
    logic prev_we_low, prev_re_n, ov_seen, to_at_done, busy_at_done;
    logic [1:0] ce_at_done;
    logic [10:0] prev_bus;
    logic [7:0] wr_b[$];
    logic [1:0] wr_k[$];
    logic [7:0] exp_q[$];
    logic [15:0] cur_col;
    logic [23:0] cur_row;

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(int i);
        return (cur_row[7:0] ^ cur_col[7:0]) + 8'(i * 37) + 8'h11;
    endfunction

    task automatic clear_mon();
        t = -1; t30 = -1; first_we = -1; done_cnt = 0; done_t = -1; re_pulses = 0;
        re_low = 0; rd_idx = 0; proto_err = 0; stall_re_err = 0; stall_cnt = 0; acc = 0;
        rb_cnt = 0; rb_rise = -1; prev_we_low = 1'b0; prev_re_n = 1'b1; ov_seen = 1'b0;
        to_at_done = 1'b0; busy_at_done = 1'b1; ce_at_done = 2'b00; prev_bus = '0;
        wr_b.delete(); wr_k.delete(); exp_q.delete();
    endtask

    // one cycle: sample at negedge, run flash model and consumer, set inputs for next edge
    task automatic tick();
        @(negedge clk_ndf);
        t++;
        if (rb_cnt > 0) begin
            rb_cnt--;
            if (rb_cnt == 0) begin
                rb = 1'b1;
                rb_rise = t;
            end
        end
        if (!m_we_n) begin
            wr_b.push_back(m_io);
            wr_k.push_back({m_cle, m_ale});
            if (!m_oe) proto_err++;
            if (first_we < 0) first_we = t;
            if (m_cle && m_io == 8'h30) begin
                t30 = t;
                rb = 1'b0;
                rb_cnt = rb_busy;
            end
        end else if (prev_we_low) begin
            if ({m_cle, m_ale, m_oe, m_io} != prev_bus) proto_err++;
        end else if (m_cle || m_ale || m_oe) begin
            proto_err++;
        end
        prev_we_low = !m_we_n;
        prev_bus = {m_cle, m_ale, m_oe, m_io};
        if (m_oe && !m_re_n) proto_err++;
        if (m_to && !m_done) proto_err++;
        if (!m_re_n) begin
            if (prev_re_n) re_pulses++;
            re_low++;
            io_in = re_low >= 2 ? mem_byte(rd_idx) : ~mem_byte(rd_idx);
        end else begin
            if (!prev_re_n) rd_idx++;
            re_low = 0;
            io_in = 8'h5A;
        end
        prev_re_n = m_re_n;
        if (m_ov && !out_ready && !m_re_n) stall_re_err++;
        if (m_ov) ov_seen = 1'b1;
        if (m_done) begin
            done_cnt++;
            done_t = t;
            to_at_done = m_to;
            ce_at_done = m_ce_n;
            busy_at_done = m_busy;
        end
        out_ready = stall_cnt == 0;
        if (stall_cnt > 0) stall_cnt--;
        if (m_ov && out_ready) begin
            if (exp_q.size() == 0) chk("extra_byte", m_od, -1);
            else chk("out_byte", m_od, exp_q.pop_front());
            acc++;
            if (acc == stall_after) stall_cnt = 10;
        end
    endtask

    task automatic run(vec_t v);
        logic [7:0] ew[$];
        logic [1:0] ek[$];
        clear_mon();
        use_b = v.use_b;
        rb = 1'b1;
        rb_busy = v.rb_busy;
        stall_after = v.stall_after;
        cur_col = v.col;
        cur_row = v.row;
        if (!v.exp_to)
            for (int i = 0; i < int'(v.cnt); i++) exp_q.push_back(mem_byte(i));
        ew = '{8'h00, v.col[7:0], v.col[15:8], v.row[7:0], v.row[15:8]};
        ek = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
        if (v.exp_nwr == 7) begin
            ew.push_back(v.row[23:16]);
            ek.push_back(2'b01);
        end
        ew.push_back(8'h30);
        ek.push_back(2'b10);
        ce_sel = v.sel;
        col_addr = v.col;
        row_addr = v.row;
        byte_count = v.cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_on_start", m_busy, 1);
        chk("ce_n", m_ce_n, v.exp_ce);
        while (done_cnt == 0 && t < 3000) begin
            if (v.again && t == 4) begin
                start = 1'b1;
                col_addr = ~v.col;
                row_addr = ~v.row;
                ce_sel = ~v.sel;
            end
            tick();
            start = 1'b0;
        end
        if (v.start_done) start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            start = 1'b0;
        end
        chk("done_count", done_cnt, 1);
        chk("timeout_err", to_at_done, v.exp_to);
        chk("ce_at_done", ce_at_done, 2'b11);
        chk("busy_at_done", busy_at_done, 0);
        chk("n_writes", wr_b.size(), v.exp_nwr);
        for (int i = 0; i < wr_b.size() && i < ew.size(); i++) begin
            chk("wr_byte", wr_b[i], ew[i]);
            chk("wr_cle_ale", wr_k[i], ek[i]);
        end
        chk("first_we_fall", first_we, 1);
        chk("cmd30_w2_cycle", t30 + 1, 2 * v.exp_nwr);
        chk("protocol", proto_err, 0);
        chk("re_pulses", re_pulses, v.exp_re);
        chk("stall_re_high", stall_re_err, 0);
        chk("bytes_accepted", acc, v.exp_re);
        chk("bytes_missing", exp_q.size(), 0);
        chk("busy_end", m_busy, 0);
        if (v.exp_to) chk("timeout_latency", done_t - t30, 2 + TWB + 200);
        if (v.cnt == 0) begin
            chk("out_valid_never", ov_seen, 0);
            chk("done_after_rb", done_t > rb_rise && rb_rise >= 0, 1);
        end
    endtask

    initial begin
        tv[0] = '{1'b0, 1'b1, 16'h0123, 24'h045678, 14'd4, 100, 0, 1'b0, 1'b0, 2'b01, 7, 4, 1'b0};
        tv[1] = '{1'b0, 1'b1, 16'h0123, 24'h045678, 14'd4, 100, 2, 1'b0, 1'b1, 2'b01, 7, 4, 1'b0};
        tv[2] = '{1'b0, 1'b0, 16'h0ABC, 24'h123456, 14'd4, -1, 0, 1'b0, 1'b0, 2'b10, 7, 0, 1'b1};
        tv[3] = '{1'b0, 1'b0, 16'h7E01, 24'h00FF10, 14'd0, 30, 0, 1'b0, 1'b0, 2'b10, 7, 0, 1'b0};
        tv[4] = '{1'b1, 1'b1, 16'h4321, 24'h9ABCDE, 14'd3, 20, 0, 1'b1, 1'b0, 2'b01, 6, 3, 1'b0};
        rst_n = 1'b0;
        start = 1'b0;
        ce_sel = 1'b0;
        col_addr = '0;
        row_addr = '0;
        byte_count = '0;
        out_ready = 1'b1;
        rb = 1'b1;
        io_in = 8'h00;
        use_b = 1'b0;
        clear_mon();
        #110;
        chk("reset_a", a_pk, RST_PK);
        chk("reset_b", b_pk, RST_PK);
        @(negedge clk_ndf);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 5; i++) run(tv[i]);

        clear_mon();
        use_b = 1'b0;
        cur_col = tv[0].col;
        cur_row = tv[0].row;
        ce_sel = 1'b1;
        col_addr = tv[0].col;
        row_addr = tv[0].row;
        byte_count = tv[0].cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (t < 6) tick();
        chk("ale_before_reset", m_ale, 1);
        #10 rst_n = 1'b0;
        #1 chk("async_reset_pins", m_pk, RST_PK);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("no_done_after_reset", done_cnt, 0);
        run(tv[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ndf_page_reader.md
Name: ndf_page_reader

Overview:
- Hardware sequencer for one NAND page-read transaction on the ndf_* flash bus.
- Issues command 00h, the address cycles and command 30h, then waits for R/B (with timeout) and streams the requested bytes out on a valid/ready byte interface.
- Sits between the host-side control logic (EPP bridge or a future DMA) and the flash pins, replacing per-byte host sequencing.
- Runs on clk_ndf (20 MHz); every flash timing is met by whole clk_ndf cycles.

Parameters:
ADDR_CYCLES, 5, number of address bytes sent (4 or 5; 4 omits row[23:16])
TWB_CYC, 4, cycles to wait after the 30h WE rising edge before sampling R/B
TIMEOUT_CYC, 1000000, maximum cycles R/B may stay busy (50 ms at 20 MHz)
CNT_W, 14, width of byte_count and the internal byte counter

Ports:
clk_ndf  in  1  flash-domain clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
ce_sel  in  1  chip to enable (0 -> ndf_ce_n[0], 1 -> ndf_ce_n[1])
col_addr  in  16  column address, latched on start
row_addr  in  24  row address, latched on start
byte_count  in  CNT_W  bytes to read, latched on start
busy  out  1  high from start acceptance until the cycle done pulses
done  out  1  one-cycle completion pulse
timeout_err  out  1  one-cycle pulse coincident with done when R/B timed out
out_data  out  8  read byte
out_valid  out  1  out_data holds a byte
out_ready  in  1  consumer accepts out_data when out_valid && out_ready
ndf_r_b_n  in  1  flash ready/busy, asynchronous; 2-flop synchronised inside
ndf_io_in  in  8  flash data bus input
ndf_io_out  out  8  flash data bus drive value
ndf_io_oe  out  1  1 = drive ndf_io_out onto the bus
ndf_ce_n  out  2  chip enables, active low
ndf_cle  out  1  command latch enable
ndf_ale  out  1  address latch enable
ndf_we_n  out  1  write enable, active low
ndf_re_n  out  1  read enable, active low
ndf_wp_n  out  1  write protect; constant 0 (reads only)

Behaviour:
- Clock and reset: one clock, clk_ndf. rst_n is asynchronous and active-low. All outputs are registered.
- Reset values: ndf_ce_n=2'b11, ndf_cle=0, ndf_ale=0, ndf_we_n=1, ndf_re_n=1, ndf_wp_n=0, ndf_io_oe=0, ndf_io_out=0, busy=0, done=0, timeout_err=0, out_valid=0, out_data=0. State returns to IDLE.
- Reset mid-transaction: the bus is released immediately and the transaction is abandoned; no done pulse is produced.
- IDLE:
  - On start, latch the inputs, set busy, and drive the selected CE low on the next edge.
  - start while busy is ignored.
- Write-cycle primitive (2 cycles):
  - Cycle W1: ndf_we_n=0; CLE or ALE high; ndf_io_oe=1; ndf_io_out=byte.
  - Cycle W2: ndf_we_n=1; CLE/ALE, io and oe unchanged (hold).
  - Outside write cycles, CLE=ALE=0 and oe=0.
- State sequence after start:
  - CMD1: 00h with CLE.
  - ADDR: ADDR_CYCLES bytes with ALE, in order col[7:0], col[15:8], row[7:0], row[15:8], row[23:16].
  - CMD2: 30h with CLE.
  - The first WE falling edge is 1 cycle after start is sampled. The 30h W2 cycle is cycle 2*(ADDR_CYCLES+2); that is 14 for the default.
- TWB: wait TWB_CYC cycles with the bus idle.
- WAIT_RB:
  - Wait for synchronised R/B high, then go to READ.
  - The timeout counter starts on entry. If it reaches TIMEOUT_CYC, deassert CE and go to DONE with timeout_err=1.
- READ, per byte:
  - R1: ndf_re_n=0.
  - R2: ndf_re_n=0; capture ndf_io_in into out_data; set out_valid.
  - R3: ndf_re_n=1.
  - Repeat until byte_count bytes are captured.
  - The next R1 starts only if the output register is empty or being accepted in that cycle. Otherwise the block stalls with RE high, and no byte is ever lost or duplicated.
  - Full-throughput rate is 1 byte per 3 cycles.
- byte_count=0: skip READ and go straight to DONE after R/B is ready.
- DONE:
  - Entered when the last byte has been accepted (out_valid falls).
  - CE high; done=1 for one cycle; busy falls in the same cycle; return to IDLE.
  - start in that same cycle is ignored.
- ndf_io_oe is 0 whenever ndf_re_n is 0 (no bus fight).

Test Plan:
- Default params, start with col=0x0123, row=0x045678, ce_sel=1, byte_count=4, R/B model busy 100 cycles, out_ready=1:
  - ndf_ce_n=2'b01.
  - Bus sequence 00h, 23h, 01h, 78h, 56h, 04h, 30h, each with correct CLE/ALE on 2-cycle WE pulses.
  - 4 bytes match the model; single done pulse; timeout_err=0.
- Same transaction with out_ready held low for 10 cycles after the 2nd byte:
  - RE stays high throughout the stall.
  - Output byte stream identical to the unstalled run, with no drops or duplicates.
- R/B held low forever with TIMEOUT_CYC overridden to 200:
  - done and timeout_err pulse together exactly 200 cycles after WAIT_RB entry.
  - CE=2'b11; no RE pulses.
- byte_count=0:
  - Command and address phase still occurs.
  - done appears after R/B rises, with no RE pulses and out_valid never set.
- rst_n asserted during the ADDR phase:
  - All pins return to reset values asynchronously; no done.
  - A subsequent start performs a full clean transaction.
- ADDR_CYCLES=4 and start pulsed again while busy:
  - Only 4 ALE writes occur.
  - The second start has no effect.
